axis_frame_tagger: RTL and testbench

Output framing stage placed directly downstream of the background-removal `SYSTEM` core. It consumes the core's untagged 24-bit pixel stream (M_AXIS side of `SYSTEM`) and re-emits it as an AXI4-Stream video stream. Start-of-frame is marked on TUSER and end-of-line on TLAST, so a VDMA or a display sink can consume frames of H_ACTIVE x V_ACTIVE pixels. A 2-entry skid buffer decouples the core from downstream backpressure. Frame-done and frame-count status are reported.

---
 rtl/axis_frame_tagger.sv | 201 ++++++++++++++++++++
 tb/tb_axis_frame_tagger.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_tagger.sv
`default_nettype none
// ============================================================================
// Module   : axis_frame_tagger
// Purpose  : Re-emits an untagged pixel stream as AXI4-Stream video. The first
//            pixel of a frame is flagged on USER and the last pixel of each
//            line on LAST. A 2-entry skid buffer with registered outputs
//            isolates the upstream core from downstream backpressure.
//            Completed frames are pulsed on o_FRAME_DONE and counted.
// Ports    : i_CLK, i_RST (async, active-high), i_ENABLE (frame start permit)
//            S_AXIS_DATA/VALID/READY    - untagged pixel input
//            M_AXIS_DATA/VALID/READY    - tagged pixel output
//            M_AXIS_USER, M_AXIS_LAST   - start-of-frame / end-of-line
//            o_FRAME_DONE, o_FRAME_CNT  - frame status
// Revision : 1.0 - initial release
// ============================================================================
module axis_frame_tagger #(
   parameter int DATA_WIDTH = 24,
   parameter int H_ACTIVE   = 320,
   parameter int V_ACTIVE   = 20,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  i_CLK,
   input  logic                  i_RST,
   input  logic                  i_ENABLE,
   input  logic [DATA_WIDTH-1:0] S_AXIS_DATA,
   input  logic                  S_AXIS_VALID,
   output logic                  S_AXIS_READY,
   output logic [DATA_WIDTH-1:0] M_AXIS_DATA,
   output logic                  M_AXIS_VALID,
   input  logic                  M_AXIS_READY,
   output logic                  M_AXIS_USER,
   output logic                  M_AXIS_LAST,
   output logic                  o_FRAME_DONE,
   output logic [CNT_WIDTH-1:0]  o_FRAME_CNT
);

   // A single-line frame would give a zero-width row counter; keep >= 1 bit.
   localparam int COL_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int ROW_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_ACTIVE - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_ACTIVE - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   state_t                state, state_next;
   logic [COL_W-1:0]      col, col_next;
   logic [ROW_W-1:0]      row, row_next;
   logic                  done_next;
   logic [CNT_WIDTH-1:0]  frame_cnt;
   logic                  frame_done;

   // Skid buffer: head drives the outputs directly, tail holds the overflow.
   logic [1:0]            occ;
   logic [DATA_WIDTH-1:0] head_data, tail_data;
   logic                  head_user, head_last, tail_user, tail_last;

   logic                  push, pop, in_user, in_last;

   always_comb begin
      S_AXIS_READY = (state == STREAM) && (occ != 2'd2);
      push         = S_AXIS_VALID && S_AXIS_READY;
      pop          = (occ != 2'd0) && M_AXIS_READY;
      in_user      = (col == '0) && (row == '0);
      in_last      = (col == COL_LAST);
   end

   // ------------------------------------------------------------------------
   // Frame FSM: next state, position counters and frame-done strobe
   // ------------------------------------------------------------------------
   always_comb begin
      state_next = state;
      col_next   = col;
      row_next   = row;
      done_next  = 1'b0;
      case (state)
         IDLE: begin
            col_next = '0;
            row_next = '0;
            if (i_ENABLE) begin
               state_next = STREAM;
            end
         end
         STREAM: begin
            if (push) begin
               if (col == COL_LAST) begin
                  col_next = '0;
                  if (row == ROW_LAST) begin
                     row_next   = '0;
                     state_next = DRAIN;
                  end else begin
                     row_next = row + ROW_W'(1);
                  end
               end else begin
                  col_next = col + COL_W'(1);
               end
            end
         end
         DRAIN: begin
            // No pushes happen here, so the buffer empties exactly when the
            // last remaining beat is popped. Registering the strobe on that
            // edge puts the pulse in the cycle after the final handshake.
            if ((occ == 2'd0) || ((occ == 2'd1) && pop)) begin
               done_next  = 1'b1;
               col_next   = '0;
               row_next   = '0;
               state_next = i_ENABLE ? STREAM : IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         state      <= IDLE;
         col        <= '0;
         row        <= '0;
         frame_done <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         state      <= state_next;
         col        <= col_next;
         row        <= row_next;
         frame_done <= done_next;
         if (done_next) begin
            frame_cnt <= frame_cnt + CNT_WIDTH'(1);
         end
      end
   end

   // ------------------------------------------------------------------------
   // 2-entry skid buffer
   // ------------------------------------------------------------------------
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         occ       <= 2'd0;
         head_data <= '0;
         head_user <= 1'b0;
         head_last <= 1'b0;
         tail_data <= '0;
         tail_user <= 1'b0;
         tail_last <= 1'b0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (occ == 2'd0) begin
                  head_data <= S_AXIS_DATA;
                  head_user <= in_user;
                  head_last <= in_last;
               end else begin
                  tail_data <= S_AXIS_DATA;
                  tail_user <= in_user;
                  tail_last <= in_last;
               end
               occ <= occ + 2'd1;
            end
            2'b01: begin
               if (occ == 2'd2) begin
                  head_data <= tail_data;
                  head_user <= tail_user;
                  head_last <= tail_last;
               end
               occ <= occ - 2'd1;
            end
            2'b11: begin
               // Occupancy is unchanged; the new beat lands behind whatever
               // is still queued so ordering is preserved.
               if (occ == 2'd2) begin
                  head_data <= tail_data;
                  head_user <= tail_user;
                  head_last <= tail_last;
                  tail_data <= S_AXIS_DATA;
                  tail_user <= in_user;
                  tail_last <= in_last;
               end else begin
                  head_data <= S_AXIS_DATA;
                  head_user <= in_user;
                  head_last <= in_last;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign M_AXIS_VALID = (occ != 2'd0);
   assign M_AXIS_DATA  = head_data;
   assign M_AXIS_USER  = head_user;
   assign M_AXIS_LAST  = head_last;
   assign o_FRAME_DONE = frame_done;
   assign o_FRAME_CNT  = frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_tagger.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axis_frame_tagger
// Purpose  : Scoreboard bench for axis_frame_tagger. A 320x20 instance covers
//            nominal, backpressure, enable-drop, back-to-back and mid-frame
//            reset; a 2x1 instance covers the small geometry and counter wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_frame_tagger;

   localparam int DW    = 24;
   localparam int H     = 320;
   localparam int V     = 20;
   localparam int CW    = 16;
   localparam int FRAME = H * V;
   localparam int CW2   = 2;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          user;
      logic          last;
      logic          eof;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, en, s_valid, s_ready, m_valid, m_ready, m_user, m_last, done;
   logic [DW-1:0] s_data, m_data;
   logic [CW-1:0] cnt;

   logic          en2, s_valid2, s_ready2, m_valid2, m_ready2, m_user2, m_last2, done2;
   logic [DW-1:0] s_data2, m_data2;
   logic [CW2-1:0] cnt2;

   axis_frame_tagger #(.DATA_WIDTH(DW), .H_ACTIVE(H), .V_ACTIVE(V), .CNT_WIDTH(CW)) dut (
      .i_CLK(clk), .i_RST(rst), .i_ENABLE(en),
      .S_AXIS_DATA(s_data), .S_AXIS_VALID(s_valid), .S_AXIS_READY(s_ready),
      .M_AXIS_DATA(m_data), .M_AXIS_VALID(m_valid), .M_AXIS_READY(m_ready),
      .M_AXIS_USER(m_user), .M_AXIS_LAST(m_last),
      .o_FRAME_DONE(done), .o_FRAME_CNT(cnt)
   );

   axis_frame_tagger #(.DATA_WIDTH(DW), .H_ACTIVE(2), .V_ACTIVE(1), .CNT_WIDTH(CW2)) dut_small (
      .i_CLK(clk), .i_RST(rst), .i_ENABLE(en2),
      .S_AXIS_DATA(s_data2), .S_AXIS_VALID(s_valid2), .S_AXIS_READY(s_ready2),
      .M_AXIS_DATA(m_data2), .M_AXIS_VALID(m_valid2), .M_AXIS_READY(m_ready2),
      .M_AXIS_USER(m_user2), .M_AXIS_LAST(m_last2),
      .o_FRAME_DONE(done2), .o_FRAME_CNT(cnt2)
   );

   int    pass_cnt = 0;
   int    check_cnt = 0;
   beat_t q[$];
   beat_t q2[$];
   logic  bp_mode = 1'b0;
   logic  await_done = 1'b0;
   int    exp_frames = 0;
   int    edge_no = 0;
   int    small_k = 0;

   always @(posedge clk) edge_no <= edge_no + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      check_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic check_reset_outputs();
      check("reset s_ready", s_ready, 0);
      check("reset m_valid", m_valid, 0);
      check("reset m_data", m_data, 0);
      check("reset m_user", m_user, 0);
      check("reset m_last", m_last, 0);
      check("reset frame_done", done, 0);
      check("reset frame_cnt", cnt, 0);
   endtask

   // Offer one beat and wait (bounded) for it to be accepted.
   task automatic send_beat(input logic [DW-1:0] d, input int idx);
      int n;
      bit hs;
      s_data  = d;
      s_valid = 1'b1;
      n  = 0;
      hs = 1'b0;
      while (!hs && n < 1000) begin
         @(negedge clk);
         hs = s_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (hs) q.push_back('{d, idx == 0, (idx % H) == H - 1, idx == FRAME - 1});
      else check("s_ready wait", hs, 1);
   endtask

   task automatic send_frame(input bit gaps, input int drop_at, input int rst_at,
                             output int first_acc, output int last_acc);
      first_acc = 0;
      last_acc  = 0;
      for (int idx = 0; idx < FRAME; idx++) begin
         send_beat(DW'($urandom), idx);
         if (idx == 0) first_acc = edge_no;
         last_acc = edge_no;
         if (idx == drop_at) en = 1'b0;
         if (idx == rst_at) begin
            rst = 1'b1;
            #1;
            check_reset_outputs();
            s_valid = 1'b0;
            return;
         end
         if (gaps && $urandom_range(0, 3) == 0) begin
            s_valid = 1'b0;
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic wait_drained();
      int n;
      n = 0;
      while ((q.size() != 0 || await_done) && n < 40000) begin
         @(negedge clk);
         n++;
      end
      check("drain wait", q.size() == 0, 1);
      repeat (3) @(negedge clk);
   endtask

   // Downstream ready: always 1 unless the backpressure test is running.
   initial begin
      m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Main-instance monitor: pops and compares on every output handshake.
   initial begin
      beat_t         e;
      logic [DW+1:0] held;
      logic          stalled;
      stalled = 1'b0;
      held    = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            q.delete();
            await_done = 1'b0;
            exp_frames = 0;
            stalled    = 1'b0;
         end else begin
            if (done || await_done) begin
               check("frame_done pulse", done, await_done);
               if (done && await_done) begin
                  exp_frames++;
                  check("frame_cnt at done", cnt, 64'(CW'(exp_frames)));
               end
               await_done = 1'b0;
            end
            check("m_valid vs occupancy", m_valid, q.size() > 0);
            if (q.size() >= 2) check("s_ready low when full", s_ready, 0);
            if (stalled) check("stall hold", {m_valid, m_data, m_user, m_last}, {1'b1, held});
            if (m_valid && m_ready) begin
               stalled = 1'b0;
               if (q.size() == 0) begin
                  check("unexpected output beat", m_valid, 0);
               end else begin
                  e = q.pop_front();
                  check("beat data/user/last", {m_data, m_user, m_last}, {e.data, e.user, e.last});
                  if (e.eof) await_done = 1'b1;
               end
            end else if (m_valid) begin
               stalled = 1'b1;
               held    = {m_data, m_user, m_last};
            end else begin
               stalled = 1'b0;
            end
         end
      end
   end

   // Small-instance monitor.
   initial begin
      beat_t e;
      int    seq [5];
      seq = '{1, 2, 3, 0, 1};
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (done2) begin
               if (small_k < 5) check("small frame_cnt sequence", cnt2, 64'(seq[small_k]));
               else check("small extra frame_done", done2, 0);
               small_k++;
            end
            if (m_valid2 && m_ready2) begin
               check("small user/last exclusive", m_user2 & m_last2, 0);
               if (q2.size() == 0) begin
                  check("small unexpected beat", m_valid2, 0);
               end else begin
                  e = q2.pop_front();
                  check("small beat", {m_data2, m_user2, m_last2}, {e.data, e.user, e.last});
               end
            end
         end
      end
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, check_cnt);
      $fatal(1);
   end

   initial begin
      int f0, l0, f1, l1, any_high;
      rst = 1'b1; en = 1'b0; s_valid = 1'b0; s_data = '0;
      en2 = 1'b0; s_valid2 = 1'b0; s_data2 = '0; m_ready2 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Nominal frame, enable dropped at input beat 3000.
      en = 1'b1;
      send_frame(1'b0, 3000, -1, f0, l0);
      s_valid = 1'b0;
      wait_drained();
      check("count after nominal", cnt, 1);
      any_high = 0;
      repeat (30) begin
         @(negedge clk);
         if (s_ready) any_high = 1;
      end
      check("s_ready stays low after enable drop", any_high, 0);

      // Backpressure with input gaps.
      bp_mode = 1'b1;
      en = 1'b1;
      send_frame(1'b1, 10, -1, f0, l0);
      s_valid = 1'b0;
      wait_drained();
      bp_mode = 1'b0;
      check("count after backpressure", cnt, 2);

      // Three back-to-back frames.
      en = 1'b1;
      send_frame(1'b0, -1, -1, f0, l0);
      send_frame(1'b0, -1, -1, f1, l1);
      check("inter-frame gap 1 within 2 idle cycles", (f1 - l0) <= 3, 1);
      send_frame(1'b0, 0, -1, f0, l0);
      check("inter-frame gap 2 within 2 idle cycles", (f0 - l1) <= 3, 1);
      s_valid = 1'b0;
      wait_drained();
      check("count after back-to-back", cnt, 5);

      // Reset at input beat 1000, then a full frame.
      en = 1'b1;
      send_frame(1'b0, -1, 1000, f0, l0);
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs();
      rst = 1'b0;
      en  = 1'b1;
      send_frame(1'b0, 0, -1, f0, l0);
      s_valid = 1'b0;
      wait_drained();
      check("count after reset restart", cnt, 1);

      // Small geometry: 5 frames of 2 pixels.
      en2 = 1'b1;
      for (int f = 0; f < 5; f++) begin
         for (int i = 0; i < 2; i++) begin
            int  n;
            bit  hs;
            logic [DW-1:0] d;
            d = DW'($urandom);
            s_data2  = d;
            s_valid2 = 1'b1;
            n  = 0;
            hs = 1'b0;
            while (!hs && n < 100) begin
               @(negedge clk);
               hs = s_ready2;
               @(posedge clk);
               #1;
               n++;
            end
            if (hs) q2.push_back('{d, i == 0, i == 1, i == 1});
            else check("small s_ready wait", hs, 1);
            if (f == 4) en2 = 1'b0;
         end
      end
      s_valid2 = 1'b0;
      repeat (10) @(negedge clk);
      check("small frame_done pulses", small_k, 5);
      check("small queue drained", q2.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
`default_nettype wire
